// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32 decode stage with DEPTH-entry output FIFO
// Optional MUL/DIV decode enabled by defining DECODE_MULDIV_EN.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int OP_W  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OP_W-1:0]            out_op,
   output logic [4:0]                 out_rd,
   output logic [4:0]                 out_rs1,
   output logic [4:0]                 out_rs2,
   output logic [XLEN-1:0]            out_imm,
   output logic                       out_ill,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = OP_W + 15 + XLEN + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [OP_W-1:0] d_op;
   logic            d_ill;
   logic [11:0]     imm12;
   logic [XLEN-1:0] d_imm;
   logic [EW-1:0]   d_entry;

   logic [EW-1:0]   mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;

   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign f7     = in_instr[31:25];

   always_comb begin
      d_op  = '0;
      d_ill = 1'b1;
      imm12 = '0;
      case (opcode)
         7'b0110011: begin
            case ({f7, f3})
               10'b0000000_000: begin d_op = OP_W'(0); d_ill = 1'b0; end
               10'b0100000_000: begin d_op = OP_W'(1); d_ill = 1'b0; end
               10'b0000000_111: begin d_op = OP_W'(7); d_ill = 1'b0; end
               10'b0000000_110: begin d_op = OP_W'(8); d_ill = 1'b0; end
               10'b0000000_100: begin d_op = OP_W'(9); d_ill = 1'b0; end
`ifdef DECODE_MULDIV_EN
               10'b0000001_000: begin d_op = OP_W'(2); d_ill = 1'b0; end
               10'b0000001_100: begin d_op = OP_W'(3); d_ill = 1'b0; end
`endif
               default: ;
            endcase
         end
         7'b0010011: begin
            if (f3 == 3'b000) begin
               d_op  = OP_W'(6);
               d_ill = 1'b0;
               imm12 = in_instr[31:20];
            end
         end
         7'b0000011: begin
            if (f3 == 3'b010) begin
               d_op  = OP_W'(4);
               d_ill = 1'b0;
               imm12 = in_instr[31:20];
            end
         end
         7'b0100011: begin
            if (f3 == 3'b010) begin
               d_op  = OP_W'(5);
               d_ill = 1'b0;
               imm12 = {in_instr[31:25], in_instr[11:7]};
            end
         end
         default: ;
      endcase
   end

   assign d_imm   = {{(XLEN-12){imm12[11]}}, imm12};
   assign d_entry = {d_op, in_instr[11:7], in_instr[19:15], in_instr[24:20], d_imm, d_ill};

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign in_ready  = !full && !flush;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   // A pop during flush is dropped: the flush resets pointers anyway.
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= d_entry;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign {out_op, out_rd, out_rs1, out_rs2, out_imm, out_ill} = mem[rd_ptr];

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed table-driven bench for decode_stage
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [31:0] out_imm;
   logic        out_ill;
   logic [1:0]  count;

   int checks = 0;
   int errors = 0;

   decode_stage #(.XLEN(32), .DEPTH(2), .OP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_ill(out_ill), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        ill;
   } vec_t;

`ifdef DECODE_MULDIV_EN
   localparam logic [3:0] MUL_OP = 4'd2;
   localparam logic [3:0] DIV_OP = 4'd3;
   localparam logic       MD_ILL = 1'b0;
`else
   localparam logic [3:0] MUL_OP = 4'd0;
   localparam logic [3:0] DIV_OP = 4'd0;
   localparam logic       MD_ILL = 1'b1;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_head(input string tag, input vec_t v);
      chk({tag, " valid"}, 32'(out_valid), 32'd1);
      chk({tag, " op"},    32'(out_op),    32'(v.op));
      chk({tag, " rd"},    32'(out_rd),    32'(v.rd));
      chk({tag, " rs1"},   32'(out_rs1),   32'(v.rs1));
      chk({tag, " rs2"},   32'(out_rs2),   32'(v.rs2));
      chk({tag, " imm"},   out_imm,        v.imm);
      chk({tag, " ill"},   32'(out_ill),   32'(v.ill));
   endtask

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{32'h00500093, 4'd6, 5'd1,  5'd0,  5'd5,  32'h00000005, 1'b0};
      vecs[1]  = '{32'hFE112E23, 4'd5, 5'd28, 5'd2,  5'd1,  32'hFFFFFFFC, 1'b0};
      vecs[2]  = '{32'h022081B3, MUL_OP, 5'd3, 5'd1, 5'd2,  32'h00000000, MD_ILL};
      vecs[3]  = '{32'h002081B3, 4'd0, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0};
      vecs[4]  = '{32'h402081B3, 4'd1, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0};
      vecs[5]  = '{32'h0020F1B3, 4'd7, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0};
      vecs[6]  = '{32'h0020E1B3, 4'd8, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0};
      vecs[7]  = '{32'h0020C1B3, 4'd9, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0};
      vecs[8]  = '{32'h0220C1B3, DIV_OP, 5'd3, 5'd1, 5'd2,  32'h00000000, MD_ILL};
      vecs[9]  = '{32'hFFF32283, 4'd4, 5'd5,  5'd6,  5'd31, 32'hFFFFFFFF, 1'b0};
      vecs[10] = '{32'h7FF00093, 4'd6, 5'd1,  5'd0,  5'd31, 32'h000007FF, 1'b0};
      vecs[11] = '{32'hFFFFFFFF, 4'd0, 5'd31, 5'd31, 5'd31, 32'h00000000, 1'b1};
      vecs[12] = '{32'h00501093, 4'd0, 5'd1,  5'd0,  5'd5,  32'h00000000, 1'b1};
      vecs[13] = '{32'h202081B3, 4'd0, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b1};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready",  32'(in_ready),  32'd1);
      chk("reset count",     32'(count),     32'd0);
      chk("reset out_op",    32'(out_op),    32'd0);
      chk("reset out_imm",   out_imm,        32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single push, check head one cycle later, pop it.
      foreach (vecs[i]) begin
         in_valid = 1'b1; in_instr = vecs[i].instr;
         @(negedge clk);
         in_valid = 1'b0;
         chk_head($sformatf("vec%0d", i), vecs[i]);
         chk($sformatf("vec%0d count", i), 32'(count), 32'd1);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk($sformatf("vec%0d popped", i), 32'(count), 32'd0);
      end

      // out_ready on an empty FIFO must not underflow.
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("empty pop count", 32'(count), 32'd0);
      chk("empty pop valid", 32'(out_valid), 32'd0);

      // Back-pressure: three pushes with out_ready low.
      in_valid = 1'b1; in_instr = vecs[0].instr;
      @(negedge clk);
      in_instr = vecs[1].instr;
      @(negedge clk);
      in_instr = vecs[3].instr;
      chk("bp count full", 32'(count), 32'd2);
      chk("bp in_ready",   32'(in_ready), 32'd0);
      @(negedge clk);
      chk("bp held count", 32'(count), 32'd2);
      chk_head("bp head0", vecs[0]);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp after pop count", 32'(count), 32'd1);
      chk_head("bp head1", vecs[1]);
      chk("bp in_ready freed", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp push+pop count", 32'(count), 32'd1);
      chk_head("bp head2", vecs[3]);
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp drained", 32'(count), 32'd0);

      // Flush while full with in_valid and out_ready both high.
      in_valid = 1'b1; in_instr = vecs[4].instr;
      @(negedge clk);
      in_instr = vecs[5].instr;
      @(negedge clk);
      chk("fl full count", 32'(count), 32'd2);
      flush = 1'b1; out_ready = 1'b1; in_instr = vecs[6].instr;
      #1;
      chk("fl in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("fl count", 32'(count), 32'd0);
      chk("fl out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1; in_instr = vecs[9].instr;
      @(negedge clk);
      in_valid = 1'b0;
      chk_head("fl refill", vecs[9]);

      // Asynchronous reset with two entries queued.
      in_valid = 1'b1; in_instr = vecs[10].instr;
      @(negedge clk);
      in_valid = 1'b0;
      chk("ar pre count", 32'(count), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar out_valid", 32'(out_valid), 32'd0);
      chk("ar count",     32'(count),     32'd0);
      chk("ar in_ready",  32'(in_ready),  32'd1);
      chk("ar out_imm",   out_imm,        32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
